// File: rtl/spi_cfg_regbank_if.sv
// Bus between the SPI scan-chain cell/host side and the configuration register bank.
interface spi_cfg_regbank_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_REGS   = 16
);
  logic                           update;
  logic [DATA_WIDTH-1:0]          data_in;
  logic [ADDR_WIDTH-1:0]          addr_in;
  logic [DATA_WIDTH-1:0]          capture_data;
  logic [NUM_REGS*DATA_WIDTH-1:0] cfg_flat;
  logic                           wr_pulse;
  logic [5:0]                     wr_index;
  logic                           err_addr;
  logic [7:0]                     wr_count;

  modport master (
    output update, data_in, addr_in,
    input  capture_data, cfg_flat, wr_pulse, wr_index, err_addr, wr_count
  );

  modport slave (
    input  update, data_in, addr_in,
    output capture_data, cfg_flat, wr_pulse, wr_index, err_addr, wr_count
  );
endinterface

// File: rtl/spi_cfg_regbank.sv
// Configuration register bank behind the two-phase SPI scan cell.
// Each rising edge of the host update strobe (synchronised into clk_phase1)
// performs one write, read, status read or status clear, and the resulting
// word is presented on capture_data for shift-out on the next frame.
module spi_cfg_regbank #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 7,
  parameter int                    NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] ERR_WORD   = 16'hDEAD
) (
  input logic              clk_phase1,
  input logic              reset_n,
  spi_cfg_regbank_if.slave bus
);

  localparam logic [5:0] STATUS_IDX = 6'd63;

  // Saturating increment for the write counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic                  s1, s2, s3;
  logic                  update_event;
  logic [5:0]            idx;
  logic                  wr;
  logic                  in_range;
  logic                  is_status;
  logic                  cfg_wr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] status_word;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [DATA_WIDTH-1:0] capture_data;
  logic                  wr_pulse;
  logic [5:0]            wr_index;
  logic                  err_addr;
  logic [7:0]            wr_count;

  // Three-flop synchroniser for the asynchronous update level; preset to 1
  // so an update already high at reset release is not seen as an edge.
  always_ff @(posedge clk_phase1 or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= bus.update;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Address decode and read-back selection for the current event.
  always_comb begin
    update_event = s2 & ~s3;
    idx          = bus.addr_in[5:0];
    wr           = bus.addr_in[6];
    in_range     = (idx < 6'(NUM_REGS));
    is_status    = (idx == STATUS_IDX);
    cfg_wr       = update_event & in_range & wr;
    status_word  = {{(DATA_WIDTH-9){1'b0}}, err_addr, wr_count};
    rd_word      = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (idx == 6'(k)) rd_word = regs[k];
    end
  end

  // Configuration register file; only a write event to an implemented index changes it.
  always_ff @(posedge clk_phase1 or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else if (cfg_wr) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (idx == 6'(k)) regs[k] <= bus.data_in;
      end
    end
  end

  // Event actions: capture word, write pulse/index, sticky error and write counter.
  always_ff @(posedge clk_phase1 or negedge reset_n) begin
    if (!reset_n) begin
      capture_data <= '0;
      wr_pulse     <= 1'b0;
      wr_index     <= '0;
      err_addr     <= 1'b0;
      wr_count     <= '0;
    end else begin
      wr_pulse <= 1'b0;
      if (update_event) begin
        if (in_range) begin
          if (wr) begin
            capture_data <= bus.data_in;
            wr_pulse     <= 1'b1;
            wr_index     <= idx;
            wr_count     <= sat_inc(wr_count);
          end else begin
            capture_data <= rd_word;
          end
        end else if (is_status) begin
          if (wr) begin
            err_addr     <= 1'b0;
            wr_count     <= '0;
            capture_data <= '0;
          end else begin
            capture_data <= status_word;
          end
        end else begin
          err_addr     <= 1'b1;
          capture_data <= ERR_WORD;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign bus.cfg_flat[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
  end

  assign bus.capture_data = capture_data;
  assign bus.wr_pulse     = wr_pulse;
  assign bus.wr_index     = wr_index;
  assign bus.err_addr     = err_addr;
  assign bus.wr_count     = wr_count;

endmodule

// File: tb/tb_spi_cfg_regbank.sv
// Randomised self-checking bench for spi_cfg_regbank against a frame-level model.
module tb_spi_cfg_regbank;

  localparam int NR = 16;
  localparam int DW = 16;

  logic clk;
  logic reset_n;

  spi_cfg_regbank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(7), .NUM_REGS(NR)) bus ();

  spi_cfg_regbank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(7), .NUM_REGS(NR), .ERR_WORD(16'hDEAD)
  ) dut (
    .clk_phase1 (clk),
    .reset_n    (reset_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference state: what the register bank should hold after each frame.
  logic [15:0] m_regs [NR];
  logic [15:0] m_cap;
  logic [5:0]  m_widx;
  logic        m_err;
  int          m_cnt;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    f = '0;
    for (int k = 0; k < NR; k++) f[k*16 +: 16] = m_regs[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NR; k++) m_regs[k] = '0;
    m_cap  = '0;
    m_widx = '0;
    m_err  = 1'b0;
    m_cnt  = 0;
  endtask

  // One host frame as the register map defines it; returns whether a write pulse is due.
  task automatic model_apply(input logic [6:0] a, input logic [15:0] d, output bit pulse);
    int i;
    i = int'(a[5:0]);
    pulse = 1'b0;
    if (i < NR) begin
      if (a[6]) begin
        m_regs[i] = d;
        m_cap     = d;
        m_widx    = a[5:0];
        pulse     = 1'b1;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end else begin
        m_cap = m_regs[i];
      end
    end else if (i == 63) begin
      if (a[6]) begin
        m_err = 1'b0;
        m_cnt = 0;
        m_cap = '0;
      end else begin
        m_cap = {7'b0, m_err, 8'(m_cnt)};
      end
    end else begin
      m_err = 1'b1;
      m_cap = 16'hDEAD;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cap"},  256'(bus.capture_data), 256'(m_cap));
    chk({tag, ".flat"}, 256'(bus.cfg_flat),     model_flat());
    chk({tag, ".widx"}, 256'(bus.wr_index),     256'(m_widx));
    chk({tag, ".err"},  256'(bus.err_addr),     256'(m_err));
    chk({tag, ".cnt"},  256'(bus.wr_count),     256'(m_cnt));
  endtask

  // Drive one frame: raise update, expect the action at the third edge,
  // hold update a while longer to confirm no repeat, then drop it.
  task automatic frame(input logic [6:0] a, input logic [15:0] d, input string tag);
    bit exp_pulse;
    @(negedge clk);
    bus.addr_in = a;
    bus.data_in = d;
    bus.update  = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk({tag, ".pulse_e1"}, 256'(bus.wr_pulse), 256'(0));
    @(posedge clk); #1;
    model_apply(a, d, exp_pulse);
    chk({tag, ".pulse_e2"}, 256'(bus.wr_pulse), 256'(exp_pulse));
    check_all(tag);
    @(posedge clk); #1;
    chk({tag, ".pulse_e3"}, 256'(bus.wr_pulse), 256'(0));
    @(posedge clk); #1;
    chk({tag, ".pulse_e4"}, 256'(bus.wr_pulse), 256'(0));
    check_all({tag, ".hold"});
    @(negedge clk);
    bus.update = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    logic [6:0]  a;
    logic [15:0] d;
    n_vec = 0;
    n_err = 0;
    model_reset();

    // Reset with update already high through release: no event allowed.
    reset_n     = 1'b0;
    bus.update  = 1'b1;
    bus.addr_in = 7'h45;
    bus.data_in = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("rst_hold.pulse", 256'(bus.wr_pulse), 256'(0));
    end
    check_all("rst_hold");
    @(negedge clk);
    bus.update = 1'b0;
    repeat (3) @(posedge clk);

    // Directed write, read-back, out-of-range, status read.
    frame(7'h45, 16'hA5C3, "wr5");
    chk("wr5.reg5", 256'(bus.cfg_flat[95:80]), 256'(16'hA5C3));
    chk("wr5.cnt1", 256'(bus.wr_count), 256'(1));
    frame(7'h05, 16'h0000, "rd5");
    chk("rd5.cap", 256'(bus.capture_data), 256'(16'hA5C3));
    frame(7'h52, 16'h7777, "wr18");
    chk("wr18.cap", 256'(bus.capture_data), 256'(16'hDEAD));
    frame(7'h3F, 16'h0000, "stat");
    chk("stat.cap", 256'(bus.capture_data), 256'(16'h0101));

    // Saturate the write counter, then clear via status write.
    for (int n = 0; n < 300; n++) frame(7'h40, 16'($urandom), "sat");
    chk("sat.cnt255", 256'(bus.wr_count), 256'(255));
    frame(7'h7F, 16'hFFFF, "clr");
    chk("clr.cnt0", 256'(bus.wr_count), 256'(0));
    chk("clr.err0", 256'(bus.err_addr), 256'(0));
    chk("clr.cap0", 256'(bus.capture_data), 256'(0));

    // Reset during a pending write to index 2: nothing may be written.
    @(negedge clk);
    bus.addr_in = 7'h42;
    bus.data_in = 16'hBEEF;
    bus.update  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("midrst.pulse", 256'(bus.wr_pulse), 256'(0));
    end
    chk("midrst.reg2", 256'(bus.cfg_flat[47:32]), 256'(0));
    check_all("midrst");
    @(negedge clk);
    bus.update = 1'b0;
    repeat (3) @(posedge clk);
    frame(7'h42, 16'hBEEF, "post_rst");
    chk("post_rst.reg2", 256'(bus.cfg_flat[47:32]), 256'(16'hBEEF));

    // Random mix of writes, reads, out-of-range accesses and status operations.
    for (int n = 0; n < 250; n++) begin
      a = 7'($urandom);
      if ($urandom_range(0, 3) != 0) a[5:0] = 6'($urandom_range(0, NR - 1));
      d = 16'($urandom);
      frame(a, d, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time guard so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_cfg_regbank.md
Name: spi_cfg_regbank

Overview:
- Consumer of the two-phase SPI scan-chain cell, clocked on clk_phase1.
- On each host update strobe it decodes the cell's parallel address/data outputs.
- It writes or reads one of NUM_REGS 16-bit configuration registers, or a status register.
- It returns the read-back/echo word on capture_data, which feeds the cell's capture_in for shift-out on the next frame.
- It drives the flattened configuration word bus into the CNN datapath.

Parameters:
- DATA_WIDTH, 16, register and data width.
- ADDR_WIDTH, 7, chain address width; bit 6 = write flag, bits 5:0 = register index.
- NUM_REGS, 16, implemented config registers at indices 0..NUM_REGS-1; legal range 1..63.
- ERR_WORD, 16'hDEAD, capture_data value for an out-of-range index.

Ports:
- clk_phase1  input  1  block clock; same phase-1 clock as the scan cell.
- reset_n  input  1  asynchronous, active-low reset.
- update  input  1  host frame-complete strobe; asynchronous to clk_phase1; level held high at least 3 clk_phase1 cycles.
- data_in  input  DATA_WIDTH  from scan cell data_out; stable while update is high.
- addr_in  input  ADDR_WIDTH  from scan cell addr_out; stable while update is high.
- capture_data  output  DATA_WIDTH  read-back/echo word to scan cell capture_in.
- cfg_flat  output  NUM_REGS*DATA_WIDTH  all config registers; reg k occupies bits [16k+15:16k].
- wr_pulse  output  1  one-cycle pulse on each successful config write.
- wr_index  output  6  index of the last successful config write.
- err_addr  output  1  sticky: an out-of-range index was accessed.
- wr_count  output  8  successful config writes, saturating.

Behaviour:
- Reset (async, reset_n low): every config register, capture_data, wr_pulse, wr_index, err_addr and wr_count go to 0.
- Reset also sets sync stages s1, s2 and s3 to 1. As a result, update held high through reset release produces no event; a low-then-high transition is required.
- Synchronizer: s1<=update, s2<=s1, s3<=s2 on each clk_phase1 edge. event = s2 & ~s3, a combinational decode.
- Latency: update rises before edge E0. s1 goes high at E0, s2 at E1, and event is high between E1 and E2. All actions below are registered at E2. Exactly one event per rising edge of update; a long high level does not repeat the action.
- At an event, with idx = addr_in[5:0] and wr = addr_in[6]:
  - idx < NUM_REGS, wr=1: reg[idx]<=data_in; capture_data<=data_in (echo); wr_pulse=1 for that one cycle; wr_index<=idx; wr_count<=min(wr_count+1, 255).
  - idx < NUM_REGS, wr=0: capture_data<=reg[idx]; registers unchanged; no pulse.
  - idx = 63, wr=0: capture_data<={7'b0, err_addr, wr_count}.
  - idx = 63, wr=1: err_addr<=0; wr_count<=0 (clear wins; no increment); capture_data<=0; no wr_pulse.
  - NUM_REGS <= idx <= 62: err_addr<=1; capture_data<=ERR_WORD; no register change; no pulse; wr_count unchanged.
- Outside event cycles, all outputs hold and wr_pulse is 0.
- cfg_flat is a direct wire of the registers, so a new value is visible from E2.
- wr_count saturates at 255; further writes keep it at 255.
- Reset asserted mid-sequence (between E0 and E2): the pending event is discarded and nothing is written.
- update pulses shorter than 2 cycles may be missed; this is outside the contract.

Test Plan:
- Reset, then update held high while reset_n releases -> no wr_pulse; cfg_flat=0, capture_data=0.
- addr_in=7'h45 (write, idx 5), data_in=16'hA5C3, update 0->1 -> reg5=A5C3 at the 3rd clk_phase1 edge; wr_pulse high exactly 1 cycle; wr_index=5; wr_count=1; capture_data=A5C3.
- addr_in=7'h05 (read idx 5), data_in=16'h0000 -> capture_data=A5C3; reg5 unchanged; wr_count=1.
- addr_in=7'h52 (write idx 18, NUM_REGS=16) -> err_addr=1; capture_data=DEAD; cfg_flat unchanged. Then read idx 63 -> capture_data=16'h0101.
- 300 write events to idx 0 -> wr_count=255. Then write idx 63 -> wr_count=0, err_addr=0, capture_data=0, no wr_pulse.
- Start a write to idx 2, then pulse reset_n low after 1 cycle -> reg2=0, no wr_pulse; a subsequent normal write succeeds.
